pedestrian_request_scheduler: RTL and testbench

- Sits between the raw pedestrian buttons (botao_A, botao_B) and the intersection controller.
- Synchronises and debounces both buttons, then latches each press as a pending request.
- Arbitrates A vs B round-robin and issues one held grant at a time to the controller, using a grant/ack handshake.
- Enforces a minimum gap between served crossings, plus an ack timeout.

---
 rtl/pedestrian_request_scheduler_pkg.sv | 22 ++
 rtl/pedestrian_request_scheduler_button_debouncer.sv | 49 ++++
 rtl/pedestrian_request_scheduler.sv | 145 ++++++++++++++
 tb/tb_pedestrian_request_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pedestrian_request_scheduler_pkg.sv
// Shared types and helpers for the pedestrian request scheduler: FSM state
// encoding, arbitration side encoding and counter sizing.
package pedestrian_request_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    GAP     = 2'd3
  } sched_state_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  // Bits needed to hold the values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/pedestrian_request_scheduler_button_debouncer.sv
// One pedestrian button: 2-FF synchroniser, stability-count debouncer and a
// one-cycle pulse on each rising edge of the debounced level.
module button_debouncer
  import pedestrian_request_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= btn;
      sync_2  <= sync_1;
      level_d <= level;
      // The count only runs while the synchronised input disagrees with the
      // debounced level, so it never passes CNT_LAST and cannot wrap.
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/pedestrian_request_scheduler.sv
// Latches debounced pedestrian presses as pending requests and hands them to
// the intersection controller one at a time, round-robin, with a min gap.
module pedestrian_request_scheduler
  import pedestrian_request_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GAP         = 10,
  parameter int ACK_TIMEOUT     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       botao_A,
  input  logic       botao_B,
  input  logic       phase_busy,
  input  logic       grant_ack,
  output logic       grant_A,
  output logic       grant_B,
  output logic       pending_A,
  output logic       pending_B,
  output logic       ack_timeout_err,
  output logic [1:0] state_dbg
);

  // Handshake: grant_X rises on leaving IDLE and is held until grant_ack is
  // sampled high in GRANT_X (accept) or ACK_TIMEOUT cycles elapse (withdraw);
  // grant_ack is ignored in every other state.

  localparam int TW = cnt_width(ACK_TIMEOUT);
  localparam int GW = cnt_width(MIN_GAP);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP);

  sched_state_t  state;
  sched_state_t  state_next;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_next;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_cnt_next;
  side_t         last_served;
  side_t         last_served_next;
  logic          err_set;
  logic          clr_a;
  logic          clr_b;
  logic          rise_a;
  logic          rise_b;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .btn   (botao_A),
    .rise  (rise_a)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .btn   (botao_B),
    .rise  (rise_b)
  );

  always_comb begin
    state_next       = state;
    to_cnt_next      = '0;
    gap_cnt_next     = gap_cnt;
    last_served_next = last_served;
    err_set          = 1'b0;
    clr_a            = 1'b0;
    clr_b            = 1'b0;
    case (state)
      IDLE: begin
        if (!phase_busy) begin
          if (pending_A && pending_B) begin
            state_next = (last_served == SIDE_A) ? GRANT_B : GRANT_A;
          end else if (pending_A) begin
            state_next = GRANT_A;
          end else if (pending_B) begin
            state_next = GRANT_B;
          end
        end
      end
      GRANT_A: begin
        if (grant_ack) begin
          clr_a            = 1'b1;
          last_served_next = SIDE_A;
          gap_cnt_next     = GAP_LOAD;
          state_next       = GAP;
        end else if (to_cnt == TO_LAST) begin
          err_set      = 1'b1;
          gap_cnt_next = GAP_LOAD;
          state_next   = GAP;
        end else begin
          to_cnt_next = to_cnt + TW'(1);
        end
      end
      GRANT_B: begin
        if (grant_ack) begin
          clr_b            = 1'b1;
          last_served_next = SIDE_B;
          gap_cnt_next     = GAP_LOAD;
          state_next       = GAP;
        end else if (to_cnt == TO_LAST) begin
          err_set      = 1'b1;
          gap_cnt_next = GAP_LOAD;
          state_next   = GAP;
        end else begin
          to_cnt_next = to_cnt + TW'(1);
        end
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt - GW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      to_cnt          <= '0;
      gap_cnt         <= '0;
      last_served     <= SIDE_B;
      ack_timeout_err <= 1'b0;
      pending_A       <= 1'b0;
      pending_B       <= 1'b0;
    end else begin
      state           <= state_next;
      to_cnt          <= to_cnt_next;
      gap_cnt         <= gap_cnt_next;
      last_served     <= last_served_next;
      ack_timeout_err <= ack_timeout_err | err_set;
      // A fresh press landing with the ack of the same side stays pending.
      pending_A       <= rise_a | (pending_A & ~clr_a);
      pending_B       <= rise_b | (pending_B & ~clr_b);
    end
  end

  assign grant_A   = (state == GRANT_A);
  assign grant_B   = (state == GRANT_B);
  assign state_dbg = state;

endmodule

// File: tb/tb_pedestrian_request_scheduler.sv
// Directed scenarios for the pedestrian request scheduler; expected output
// changes (cycle, outputs) are queued up front and matched by a monitor.
module tb_pedestrian_request_scheduler;

  localparam int W = 21;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       botao_A = 1'b0;
  logic       botao_B = 1'b0;
  logic       phase_busy = 1'b0;
  logic       grant_ack = 1'b0;
  logic       grant_A;
  logic       grant_B;
  logic       pending_A;
  logic       pending_B;
  logic       ack_timeout_err;
  logic [1:0] state_dbg;
  logic [4:0] out_vec;
  logic [15:0] cyc;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  pedestrian_request_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .MIN_GAP        (10),
    .ACK_TIMEOUT    (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .botao_A         (botao_A),
    .botao_B         (botao_B),
    .phase_busy      (phase_busy),
    .grant_ack       (grant_ack),
    .grant_A         (grant_A),
    .grant_B         (grant_B),
    .pending_A       (pending_A),
    .pending_B       (pending_B),
    .ack_timeout_err (ack_timeout_err),
    .state_dbg       (state_dbg)
  );

  // Clock and edge counter: cyc == k just after the k-th edge since reset release.
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= '0;
    else        cyc <= cyc + 16'd1;
  end

  assign out_vec = {grant_A, grant_B, pending_A, pending_B, ack_timeout_err};

  // Monitor: every change of the output vector pops one expected event.
  initial begin
    logic [4:0]   prev;
    logic [W-1:0] exp_item;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = '0;
      end else begin
        checks++;
        if (grant_A && grant_B) begin
          errors++;
          $display("FAIL grant_exclusive cycle %0d got A=%b B=%b required not both", cyc, grant_A, grant_B);
        end
        if (out_vec != prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cycle %0d got outs %b required no change", cyc, out_vec);
          end else begin
            exp_item = exp_q.pop_front();
            if ({cyc, out_vec} !== exp_item) begin
              errors++;
              $display("FAIL event got cycle %0d outs %b required cycle %0d outs %b",
                       cyc, out_vec, exp_item[20:5], exp_item[4:0]);
            end
          end
          prev = out_vec;
        end
      end
    end
  end

  // Driver tasks
  task automatic before_edge(input int k);
    while (int'(cyc) < k - 1) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_ev(input int c, input logic [4:0] v);
    exp_q.push_back({16'(c), v});
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    botao_A    = 1'b0;
    botao_B    = 1'b0;
    phase_busy = 1'b0;
    grant_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic pulse_ack(input int k);
    before_edge(k);
    grant_ack = 1'b1;
    before_edge(k + 1);
    grant_ack = 1'b0;
  endtask

  task automatic drain(input string name, input int k);
    before_edge(k);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got %0d events outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp_v);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_val("reset_outs", {3'b0, out_vec}, 8'h00);
    check_val("reset_state", {6'b0, state_dbg}, 8'h00);
    reset = 1'b1;

    // S1: A held -> pending 7, grant 8, ack 12; B pressed during gap waits until 23
    do_reset();
    expect_ev(7,  5'b00100);
    expect_ev(8,  5'b10100);
    expect_ev(12, 5'b00000);
    expect_ev(16, 5'b00010);
    expect_ev(23, 5'b01010);
    expect_ev(25, 5'b00000);
    before_edge(1);  botao_A = 1'b1;
    before_edge(10); botao_B = 1'b1;
    pulse_ack(12);
    pulse_ack(25);
    botao_A = 1'b0;
    botao_B = 1'b0;
    drain("s1", 40);

    // S2: 3-cycle glitch rejected, 5-cycle pulse accepted
    do_reset();
    expect_ev(16, 5'b00010);
    expect_ev(17, 5'b01010);
    expect_ev(19, 5'b00000);
    before_edge(1);  botao_B = 1'b1;
    before_edge(4);  botao_B = 1'b0;
    before_edge(10); botao_B = 1'b1;
    before_edge(15); botao_B = 1'b0;
    pulse_ack(19);
    drain("s2", 30);

    // S3: simultaneous presses, round-robin over two rounds
    do_reset();
    expect_ev(7,  5'b00110);
    expect_ev(8,  5'b10110);
    expect_ev(10, 5'b00010);
    expect_ev(21, 5'b01010);
    expect_ev(23, 5'b00000);
    expect_ev(36, 5'b00110);
    expect_ev(37, 5'b10110);
    expect_ev(38, 5'b00010);
    expect_ev(49, 5'b01010);
    expect_ev(50, 5'b00000);
    before_edge(1); botao_A = 1'b1; botao_B = 1'b1;
    pulse_ack(10);
    botao_A = 1'b0; botao_B = 1'b0;
    pulse_ack(23);
    before_edge(30); botao_A = 1'b1; botao_B = 1'b1;
    pulse_ack(38);
    before_edge(40); botao_A = 1'b0; botao_B = 1'b0;
    pulse_ack(50);
    drain("s3", 60);

    // S4: ack timeout after 32 cycles, sticky error, reissue after gap
    do_reset();
    expect_ev(7,  5'b00100);
    expect_ev(8,  5'b10100);
    expect_ev(40, 5'b00101);
    expect_ev(51, 5'b10101);
    expect_ev(53, 5'b00001);
    before_edge(1);  botao_A = 1'b1;
    before_edge(10); botao_A = 1'b0;
    pulse_ack(53);
    drain("s4", 60);

    // S5: phase_busy holds off the grant until it falls
    do_reset();
    expect_ev(7,  5'b00010);
    expect_ev(15, 5'b01010);
    expect_ev(16, 5'b00000);
    before_edge(1);  phase_busy = 1'b1; botao_B = 1'b1;
    before_edge(10); botao_B = 1'b0;
    before_edge(15); phase_busy = 1'b0;
    pulse_ack(16);
    drain("s5", 25);

    // S6: reset mid-grant clears everything at once; no grant until a new press
    do_reset();
    expect_ev(7,  5'b00010);
    expect_ev(8,  5'b01010);
    expect_ev(11, 5'b01110);
    before_edge(1); botao_B = 1'b1;
    before_edge(5); botao_A = 1'b1;
    drain("s6a", 14);
    reset   = 1'b0;
    botao_A = 1'b0;
    botao_B = 1'b0;
    #1;
    check_val("async_reset_outs", {3'b0, out_vec}, 8'h00);
    check_val("async_reset_state", {6'b0, state_dbg}, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    expect_ev(26, 5'b00100);
    expect_ev(27, 5'b10100);
    expect_ev(28, 5'b00000);
    before_edge(20); botao_A = 1'b1;
    pulse_ack(28);
    before_edge(30); botao_A = 1'b0;
    drain("s6b", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
